// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-cycle-latency memory port feeding a 3-entry instruction buffer.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched_o transfer counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    input  logic [15:0] pc_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [15:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o
`endif
);

    logic [31:0] pc_q;
    logic [31:0] resp_pc_q;
    logic        inflight_q;
    logic [15:0] buf_instr_q [FIFO_DEPTH];
    logic [31:0] buf_pc_q    [FIFO_DEPTH];
    logic [1:0]  rd_ptr_q;
    logic [1:0]  wr_ptr_q;
    logic [1:0]  count_q;

    logic [2:0]  occupancy;
    logic        issue;
    logic        push;
    logic        pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Buffered entries plus the response still on its way back bound how far ahead we fetch.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue     = !redirect_i && (occupancy < 3'(FIFO_DEPTH));
    assign push      = inflight_q && !redirect_i;

    // Handshake: the head moves downstream on a cycle where instr_valid_o and
    // instr_ready_i are both 1; valid never depends on ready, and the head stays
    // put while valid is held without ready. A redirect kills valid that cycle.
    assign instr_valid_o = (count_q != 2'd0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;

    assign pc_o       = pc_q;
    assign instr_o    = buf_instr_q[rd_ptr_q];
    assign instr_pc_o = buf_pc_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else if (redirect_i) begin
            // Flush everything, including the response that is about to arrive.
            pc_q       <= {redirect_pc_i[31:1], 1'b0};
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (issue) begin
                pc_q      <= pc_q + 32'd2;
                resp_pc_q <= pc_q;
            end
            inflight_q <= issue;
            if (push) begin
                buf_instr_q[wr_ptr_q] <= pc_data_i;
                buf_pc_q[wr_ptr_q]    <= resp_pc_q;
                wr_ptr_q              <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (pop) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_fetched_o = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized ready/redirect/reset traffic,
// checked against an in-order instruction-stream model. Honours FETCH_PERF_CNT_EN.
module tb_fetch_unit;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] pc;
    logic [15:0] pc_data;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic        valid;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_ready;
    logic [31:0] w_pc;
    logic [15:0] w_pc_data;
    logic [15:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf;
    logic [31:0] w_perf;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(3)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_o          (pc),
        .pc_data_i     (pc_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (valid),
        .instr_ready_i (ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o(perf)
`endif
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(3)) u_dut_wrap (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_o          (w_pc),
        .pc_data_i     (w_pc_data),
        .redirect_i    (w_redirect),
        .redirect_pc_i (w_redirect_pc),
        .instr_o       (w_instr),
        .instr_pc_o    (w_instr_pc),
        .instr_valid_o (w_valid),
        .instr_ready_i (w_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o(w_perf)
`endif
    );

    // Instruction memory contents; 0x1000-0x1FFF is unmapped and reads as zero.
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 16'h1111;
        if (a == 32'h2) return 16'h2222;
        if (a[31:12] == 20'h00001) return 16'h0000;
        return a[16:1] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    always @(posedge clk) begin
        pc_data   <= mem_word(pc);
        w_pc_data <= mem_word(w_pc);
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] seq_pc;
    logic [31:0] perf_exp;
    bit          live = 0;
    int          stall = 0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back(seq_pc);
            seq_pc = seq_pc + 32'd2;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] start_pc);
        exp_q.delete();
        seq_pc = start_pc;
        top_up();
    endfunction

    // One clock cycle: check current outputs against the stream model, advance model, step.
    task automatic tick();
        logic [31:0] ahead;
        #1;
        if (live) begin
            if (redirect === 1'b1 && rst === 1'b0)
                chk("redirect_kills_valid", 48'(valid), 48'(1'b0));
            if (valid === 1'b1) begin
                chk("head_pc", 48'(instr_pc), 48'(exp_q[0]));
                chk("head_instr", 48'(instr), 48'(mem_word(exp_q[0])));
            end
            ahead = pc - exp_q[0];
            chk("pc_window", 48'(ahead <= 32'd6), 48'(1'b1));
`ifdef FETCH_PERF_CNT_EN
            chk("perf_count", 48'(perf), 48'(perf_exp));
`endif
        end
        if (rst) begin
            live = 1;
            model_restart(32'h0000_0000);
            perf_exp = '0;
            stall = 0;
        end else if (live) begin
            if (redirect) begin
                model_restart({redirect_pc[31:1], 1'b0});
                stall = 0;
            end else begin
                if (valid && ready) begin
                    void'(exp_q.pop_front());
                    top_up();
                    perf_exp = perf_exp + 32'd1;
                end
                if (valid) stall = 0;
                else stall++;
                chk("refill_latency", 48'(stall <= 2), 48'(1'b1));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] head_before;
    logic [31:0] tgt;

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        ready = 1'b1;
        w_redirect = 1'b0;
        w_redirect_pc = '0;
        w_ready = 1'b1;
        @(negedge clk);
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 48'(valid), 48'(1'b0));
        chk("rst_instr", 48'(instr), 48'(16'h0));
        chk("rst_instr_pc", 48'(instr_pc), 48'(32'h0));
        chk("rst_pc", 48'(pc), 48'(32'h0));
        chk("rst_wrap_pc", 48'(w_pc), 48'(WRAP_PC));
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf", 48'(perf), 48'(32'h0));
`endif

        // Release: first valid in the third cycle, then back-to-back
        rst = 1'b0;
        chk("rel_c0_valid", 48'(valid), 48'(1'b0));
        tick();
        chk("rel_c1_valid", 48'(valid), 48'(1'b0));
        tick();
        chk("rel_c2_valid", 48'(valid), 48'(1'b1));
        chk("rel_c2_pc", 48'(instr_pc), 48'(32'h0));
        chk("rel_c2_instr", 48'(instr), 48'(16'h1111));
        chk("wrap_c2_valid", 48'(w_valid), 48'(1'b1));
        chk("wrap_c2_pc", 48'(w_instr_pc), 48'(32'hFFFF_FFFC));
        tick();
        chk("rel_c3_valid", 48'(valid), 48'(1'b1));
        chk("rel_c3_pc", 48'(instr_pc), 48'(32'h2));
        chk("rel_c3_instr", 48'(instr), 48'(16'h2222));
        chk("wrap_c3_pc", 48'(w_instr_pc), 48'(32'hFFFF_FFFE));
        tick();
        chk("wrap_c4_valid", 48'(w_valid), 48'(1'b1));
        chk("wrap_c4_pc", 48'(w_instr_pc), 48'(32'h0));
        chk("wrap_c4_instr", 48'(w_instr), 48'(16'h1111));

        // Backpressure from reset: buffer fills, fetch stops at 6
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        repeat (10) tick();
        chk("full_pc", 48'(pc), 48'(32'h6));
        chk("full_valid", 48'(valid), 48'(1'b1));
        chk("full_head_pc", 48'(instr_pc), 48'(32'h0));
        chk("full_head_instr", 48'(instr), 48'(16'h1111));
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 48'(valid), 48'(1'b1));
            chk("drain_pc", 48'(instr_pc), 48'(32'(2 * i)));
            tick();
        end

        // Redirect with a full buffer to an odd target
        ready = 1'b0;
        repeat (4) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0041;
        #1 chk("redir_valid_now", 48'(valid), 48'(1'b0));
        tick();
        redirect = 1'b0;
        ready = 1'b1;
        chk("redir_pc", 48'(pc), 48'(32'h40));
        chk("redir_r1_valid", 48'(valid), 48'(1'b0));
        tick();
        chk("redir_r2_valid", 48'(valid), 48'(1'b0));
        tick();
        chk("redir_r3_valid", 48'(valid), 48'(1'b1));
        chk("redir_r3_pc", 48'(instr_pc), 48'(32'h40));
        chk("redir_r3_instr", 48'(instr), 48'(mem_word(32'h40)));
        tick();

        // Redirect coincident with a transfer: the head is discarded and not counted
        chk("coinc_valid", 48'(valid), 48'(1'b1));
        head_before = instr_pc;
        redirect = 1'b1;
        redirect_pc = 32'h0000_1000;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk("coinc_valid_after", 48'(valid), 48'(1'b1));
        chk("coinc_new_head", 48'(instr_pc), 48'(32'h1000));
        chk("coinc_not_old", 48'(instr_pc != head_before), 48'(1'b1));
        chk("unmapped_zero", 48'(instr), 48'(16'h0000));

        // Reset mid-stream with two entries buffered
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        repeat (3) tick();
        chk("mid_pc_before", 48'(pc), 48'(32'h6));
        chk("mid_valid_before", 48'(valid), 48'(1'b1));
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 48'(valid), 48'(1'b0));
        chk("mid_rst_pc", 48'(pc), 48'(32'h0));
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_perf", 48'(perf), 48'(32'h0));
`endif
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0: tgt = 32'($urandom_range(0, 255));
                1: tgt = 32'h0000_1000 + 32'($urandom_range(0, 4095));
                default: tgt = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            endcase
            redirect_pc = tgt;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        redirect = 1'b0;
        ready = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
